pwm8_capture: RTL and testbench
===============================

// Module: pwm8_capture
// PURPOSE
//   Receive-side counterpart of the 8-bit PWM generator. Samples an external
//   PWM waveform, measures high time and period in clk cycles, and recovers
//   the 8-bit duty code the generator was driven with.
//   Sits in the sensor/feedback path.
//   One result per PWM period, plus flags for period errors and loss of signal.
// PARAMETERS
//   WIDTH   8    duty code width; nominal period PER = 2**WIDTH clk cycles
// PORTS
//   clk       in   1      system clock, sole clock domain
//   rst       in   1      asynchronous, active-high reset
//   PWM_sig   in   1      PWM input, asynchronous to clk
//   duty      out  WIDTH  last recovered duty code, held between reports
//   duty_vld  out  1      1-cycle pulse when duty/per_err update
//   per_err   out  1      valid with duty_vld: measured period != PER
//   sig_lost  out  1      level: input low for PER consecutive cycles
// BEHAVIOUR
//   Reset: duty=0, duty_vld=0, per_err=0, sig_lost=0.
//     Sync flops=0, state=IDLE, hi_cnt=lo_cnt=0, primed=0.
//   Input path:
//     - 2-flop synchronizer, then prev flop.
//     - rise = s2 & ~prev; fall = ~s2 & prev.
//   Counters: hi_cnt, lo_cnt are WIDTH+1 bits and saturate at PER.
//   FSM states:
//     - IDLE: wait for rise -> HIGH; hi_cnt=1, lo_cnt=0.
//     - HIGH: hi_cnt++ each cycle s2=1.
//         fall -> LOW; lo_cnt=1.
//         If hi_cnt==PER (stuck high, duty code all-ones): report when primed
//         with duty={WIDTH{1}}, per_err=0; reload hi_cnt=1; stay in HIGH.
//     - LOW: lo_cnt++ each cycle s2=0.
//         rise -> HIGH; report when primed, then set primed=1;
//         hi_cnt=1, lo_cnt=0.
//         If lo_cnt==PER: sig_lost=1, primed=0 -> IDLE.
//   Report (registered):
//     - duty = hi_cnt-1, truncated to WIDTH bits (the generator's high time
//       is duty+1 cycles).
//     - per_err = (hi_cnt+lo_cnt != PER).
//     - duty_vld=1 for one cycle.
//   primed: the first period after IDLE is partial/unknown.
//     - It is discarded, so the first duty_vld comes on the 3rd rise.
//   Latency: duty_vld is high after the 3rd clk edge that samples PWM_sig high
//     (sync 2 + report register).
//   sig_lost: cleared on the next rise; duty holds its last value.
//   Simultaneous events: a rise in LOW takes priority over lo_cnt==PER
//     in the same cycle (report, no sig_lost).
//   Glitches shorter than 1 clk: not filtered. A 1-cycle pulse is a valid
//     measurement (duty=0).
//   Reset mid-operation: all state cleared at once; no partial report; re-prime.
// STRUCTURE
//   Package pwm_pkg:
//     - WIDTH default.
//     - PER localparam function.
//     - State enum {IDLE, HIGH, LOW} as 2-bit localparams.
//   Sub-module pwm_sync_edge: 2-flop sync + prev flop; outputs s2, rise, fall.
//   Top: FSM, the two counters, and the report register.
// TESTING (drive PWM_sig from a reference model of the 8-bit generator)
//   - duty=0x80 -> from 3rd rise, duty_vld every 256 cycles; duty=0x80,
//     per_err=0.
//   - duty=0x00 and duty=0xFE -> duty reports 0x00 / 0xFE, per_err=0,
//     sig_lost stays 0.
//   - duty=0xFF (constant high) -> duty_vld every 256 cycles with
//     duty=0xFF, per_err=0.
//   - Hold low 256 cycles -> sig_lost=1 on the 256th low cycle, no
//     duty_vld; resume duty=0x40 -> sig_lost clears at 1st rise, first
//     report of 0x40 at 3rd rise.
//   - Period 200, high 50 -> duty=0x31, per_err=1 with each duty_vld.
//   - rst pulse mid-HIGH at duty=0x80 -> outputs 0 at once; no duty_vld
//     until the 3rd rise after release.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM capture block: default width,
// nominal period helper and the capture FSM state encoding.
package pwm_pkg;

    localparam int WIDTH_DEF = 8;

    function automatic int per_of(input int w);
        return 1 << w;
    endfunction

    localparam int PER_DEF = per_of(WIDTH_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_e;

endpackage

// File: rtl/pwm8_capture_if.sv
// Signal bundle between the PWM source side and the capture block.
// master drives the waveform and observes the results; slave is the DUT.
interface pwm8_capture_if #(
    parameter int WIDTH = pwm_pkg::WIDTH_DEF
);
    logic             PWM_sig;
    logic [WIDTH-1:0] duty;
    logic             duty_vld;
    logic             per_err;
    logic             sig_lost;

    modport master (
        output PWM_sig,
        input  duty,
        input  duty_vld,
        input  per_err,
        input  sig_lost
    );

    modport slave (
        input  PWM_sig,
        output duty,
        output duty_vld,
        output per_err,
        output sig_lost
    );
endinterface

// File: rtl/pwm_sync_edge.sv
// Two-flop synchronizer for the asynchronous PWM input plus a
// history flop, giving the clean level and its edge strobes.
module pwm_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic s2,
    output logic rise,
    output logic fall
);
    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic prev_q, prev_d;

    always_comb begin
        s1_d   = din;
        s2_d   = s1_q;
        prev_d = s2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
        end
    end

    assign s2   = s2_q;
    assign rise = s2_q & ~prev_q;
    assign fall = ~s2_q & prev_q;
endmodule

// File: rtl/pwm8_capture.sv
// Measures high time and period of an incoming PWM waveform and
// recovers the generator duty code, with period-error and loss flags.
module pwm8_capture
    import pwm_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input logic           clk,
    input logic           rst,
    pwm8_capture_if.slave bus
);
    localparam int CW = WIDTH + 1;
    localparam logic [CW-1:0] PER_C = CW'(per_of(WIDTH));
    localparam logic [CW-1:0] ONE_C = CW'(1);

    logic s2, rise, fall;

    state_e state_q, state_d;
    logic [CW-1:0] hi_q, hi_d;
    logic [CW-1:0] lo_q, lo_d;
    logic primed_q, primed_d;
    logic lost_q, lost_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic vld_q, vld_d;
    logic err_q, err_d;

    logic [CW:0] sum;

    pwm_sync_edge u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.PWM_sig),
        .s2   (s2),
        .rise (rise),
        .fall (fall)
    );

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] x);
        return (x == PER_C) ? x : x + ONE_C;
    endfunction

    assign sum = {1'b0, hi_q} + {1'b0, lo_q};

    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        primed_d = primed_q;
        lost_d   = lost_q;
        duty_d   = duty_q;
        vld_d    = 1'b0;
        err_d    = err_q;
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = HIGH;
                    hi_d    = ONE_C;
                    lo_d    = '0;
                    lost_d  = 1'b0;
                end
            end
            HIGH: begin
                if (fall) begin
                    state_d = LOW;
                    lo_d    = ONE_C;
                end else if (s2 && hi_q == PER_C) begin
                    // Constant high: a full period elapsed with no edge.
                    if (primed_q) begin
                        vld_d  = 1'b1;
                        duty_d = '1;
                        err_d  = 1'b0;
                    end
                    hi_d = ONE_C;
                end else if (s2) begin
                    hi_d = sat_inc(hi_q);
                end
            end
            LOW: begin
                if (rise) begin
                    if (primed_q) begin
                        vld_d  = 1'b1;
                        duty_d = hi_q[WIDTH-1:0] - WIDTH'(1);
                        err_d  = (sum != {1'b0, PER_C});
                    end
                    primed_d = 1'b1;
                    state_d  = HIGH;
                    hi_d     = ONE_C;
                    lo_d     = '0;
                end else if (lo_q == PER_C) begin
                    lost_d   = 1'b1;
                    primed_d = 1'b0;
                    state_d  = IDLE;
                end else if (!s2) begin
                    lo_d = sat_inc(lo_q);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            hi_q     <= '0;
            lo_q     <= '0;
            primed_q <= 1'b0;
            lost_q   <= 1'b0;
            duty_q   <= '0;
            vld_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            primed_q <= primed_d;
            lost_q   <= lost_d;
            duty_q   <= duty_d;
            vld_q    <= vld_d;
            err_q    <= err_d;
        end
    end

    assign bus.duty     = duty_q;
    assign bus.duty_vld = vld_q;
    assign bus.per_err  = err_q;
    assign bus.sig_lost = lost_q;
endmodule

// File: tb/tb_pwm8_capture.sv
// Directed bench: a reference 8-bit PWM generator drives the capture
// block; each scenario task checks reports against hand-derived values.
module tb_pwm8_capture;
    logic clk;
    logic rst;

    pwm8_capture_if #(.WIDTH(8)) pif ();

    pwm8_capture #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (pif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    int cyc = 0;
    int vld_total = 0;
    int err_total = 0;
    int lost_rises = 0;
    int lost_cyc = 0;
    int wide_cnt = 0;
    int gap = 0;
    int last_vld_cyc = 0;
    logic [7:0] last_duty = 8'h00;
    logic last_err = 1'b0;
    logic vld_prev = 1'b0;
    logic lost_prev = 1'b0;

    always @(negedge clk) begin
        cyc       <= cyc + 1;
        vld_prev  <= pif.duty_vld;
        lost_prev <= pif.sig_lost;
        if (pif.duty_vld === 1'b1) begin
            vld_total    <= vld_total + 1;
            gap          <= cyc - last_vld_cyc;
            last_vld_cyc <= cyc;
            last_duty    <= pif.duty;
            last_err     <= pif.per_err;
            if (pif.per_err === 1'b1) err_total <= err_total + 1;
            if (vld_prev === 1'b1) wide_cnt <= wide_cnt + 1;
        end
        if (pif.sig_lost === 1'b1 && lost_prev !== 1'b1) begin
            lost_rises <= lost_rises + 1;
            lost_cyc   <= cyc;
        end
    end

    int ph = 0;
    int start_cyc = 0;
    int b_vld, b_err, b_lost;

    // Reference generator: high while phase < hi, period per.
    task automatic drive(input int hi, input int per, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) start_cyc = cyc;
            pif.PWM_sig = (ph < hi);
            ph = (ph + 1 == per) ? 0 : ph + 1;
        end
        #1;
    endtask

    task automatic snap();
        b_vld  = vld_total;
        b_err  = err_total;
        b_lost = lost_rises;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pif.PWM_sig = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        n_chk++; if (pif.duty !== 8'h00) $display("FAIL rst_duty got %h exp 00", pif.duty); else n_pass++;
        n_chk++; if (pif.duty_vld !== 1'b0) $display("FAIL rst_vld got %b exp 0", pif.duty_vld); else n_pass++;
        n_chk++; if (pif.per_err !== 1'b0) $display("FAIL rst_err got %b exp 0", pif.per_err); else n_pass++;
        n_chk++; if (pif.sig_lost !== 1'b0) $display("FAIL rst_lost got %b exp 0", pif.sig_lost); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_duty80();
        snap();
        ph = 0;
        drive(129, 256, 6 * 256);
        n_chk++; if (vld_total - b_vld !== 4) $display("FAIL d80_cnt got %0d exp 4", vld_total - b_vld); else n_pass++;
        n_chk++; if (last_duty !== 8'h80) $display("FAIL d80_duty got %h exp 80", last_duty); else n_pass++;
        n_chk++; if (err_total - b_err !== 0) $display("FAIL d80_err got %0d exp 0", err_total - b_err); else n_pass++;
        n_chk++; if (gap !== 256) $display("FAIL d80_gap got %0d exp 256", gap); else n_pass++;
    endtask

    task automatic test_duty00_fe();
        snap();
        ph = 0;
        drive(1, 256, 3 * 256);
        n_chk++; if (vld_total - b_vld !== 3) $display("FAIL d00_cnt got %0d exp 3", vld_total - b_vld); else n_pass++;
        n_chk++; if (last_duty !== 8'h00) $display("FAIL d00_duty got %h exp 00", last_duty); else n_pass++;
        n_chk++; if (err_total - b_err !== 0) $display("FAIL d00_err got %0d exp 0", err_total - b_err); else n_pass++;
        n_chk++; if (lost_rises - b_lost !== 0) $display("FAIL d00_lost got %0d exp 0", lost_rises - b_lost); else n_pass++;
        snap();
        ph = 0;
        drive(255, 256, 3 * 256);
        n_chk++; if (vld_total - b_vld !== 3) $display("FAIL dfe_cnt got %0d exp 3", vld_total - b_vld); else n_pass++;
        n_chk++; if (last_duty !== 8'hFE) $display("FAIL dfe_duty got %h exp fe", last_duty); else n_pass++;
        n_chk++; if (err_total - b_err !== 0) $display("FAIL dfe_err got %0d exp 0", err_total - b_err); else n_pass++;
        n_chk++; if (lost_rises - b_lost !== 0) $display("FAIL dfe_lost got %0d exp 0", lost_rises - b_lost); else n_pass++;
    endtask

    task automatic test_duty_ff();
        snap();
        ph = 0;
        drive(256, 256, 3 * 256);
        n_chk++; if (vld_total - b_vld !== 3) $display("FAIL dff_cnt got %0d exp 3", vld_total - b_vld); else n_pass++;
        n_chk++; if (last_duty !== 8'hFF) $display("FAIL dff_duty got %h exp ff", last_duty); else n_pass++;
        n_chk++; if (err_total - b_err !== 0) $display("FAIL dff_err got %0d exp 0", err_total - b_err); else n_pass++;
        n_chk++; if (gap !== 256) $display("FAIL dff_gap got %0d exp 256", gap); else n_pass++;
    endtask

    task automatic test_sig_lost();
        snap();
        ph = 0;
        drive(0, 300, 300);
        n_chk++; if (vld_total - b_vld !== 0) $display("FAIL lost_novld got %0d exp 0", vld_total - b_vld); else n_pass++;
        n_chk++; if (lost_rises - b_lost !== 1) $display("FAIL lost_rise got %0d exp 1", lost_rises - b_lost); else n_pass++;
        n_chk++; if (lost_cyc - start_cyc !== 259) $display("FAIL lost_time got %0d exp 259", lost_cyc - start_cyc); else n_pass++;
        n_chk++; if (pif.sig_lost !== 1'b1) $display("FAIL lost_level got %b exp 1", pif.sig_lost); else n_pass++;
        snap();
        ph = 0;
        drive(65, 256, 20);
        n_chk++; if (pif.sig_lost !== 1'b0) $display("FAIL lost_clear got %b exp 0", pif.sig_lost); else n_pass++;
        drive(65, 256, 492);
        n_chk++; if (vld_total - b_vld !== 0) $display("FAIL d40_early got %0d exp 0", vld_total - b_vld); else n_pass++;
        drive(65, 256, 20);
        n_chk++; if (vld_total - b_vld !== 1) $display("FAIL d40_first got %0d exp 1", vld_total - b_vld); else n_pass++;
        n_chk++; if (last_duty !== 8'h40) $display("FAIL d40_duty got %h exp 40", last_duty); else n_pass++;
        n_chk++; if (last_err !== 1'b0) $display("FAIL d40_err got %b exp 0", last_err); else n_pass++;
        drive(65, 256, 236);
    endtask

    task automatic test_bad_period();
        snap();
        ph = 0;
        drive(50, 200, 1000);
        n_chk++; if (vld_total - b_vld !== 5) $display("FAIL bad_cnt got %0d exp 5", vld_total - b_vld); else n_pass++;
        n_chk++; if (err_total - b_err !== 4) $display("FAIL bad_errs got %0d exp 4", err_total - b_err); else n_pass++;
        n_chk++; if (last_duty !== 8'h31) $display("FAIL bad_duty got %h exp 31", last_duty); else n_pass++;
        n_chk++; if (last_err !== 1'b1) $display("FAIL bad_err got %b exp 1", last_err); else n_pass++;
        n_chk++; if (gap !== 200) $display("FAIL bad_gap got %0d exp 200", gap); else n_pass++;
    endtask

    task automatic test_reset_mid();
        ph = 0;
        drive(129, 256, 60);
        @(negedge clk);
        rst = 1'b1;
        pif.PWM_sig = 1'b0;
        #1;
        n_chk++; if (pif.duty !== 8'h00) $display("FAIL mid_duty got %h exp 00", pif.duty); else n_pass++;
        n_chk++; if (pif.duty_vld !== 1'b0) $display("FAIL mid_vld got %b exp 0", pif.duty_vld); else n_pass++;
        n_chk++; if (pif.per_err !== 1'b0) $display("FAIL mid_err got %b exp 0", pif.per_err); else n_pass++;
        n_chk++; if (pif.sig_lost !== 1'b0) $display("FAIL mid_lost got %b exp 0", pif.sig_lost); else n_pass++;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        snap();
        ph = 0;
        drive(0, 256, 100);
        ph = 0;
        drive(129, 256, 600);
        n_chk++; if (vld_total - b_vld !== 1) $display("FAIL mid_cnt got %0d exp 1", vld_total - b_vld); else n_pass++;
        n_chk++; if (last_vld_cyc - start_cyc !== 515) $display("FAIL mid_lat got %0d exp 515", last_vld_cyc - start_cyc); else n_pass++;
        n_chk++; if (last_duty !== 8'h80) $display("FAIL mid_duty2 got %h exp 80", last_duty); else n_pass++;
        n_chk++; if (wide_cnt !== 0) $display("FAIL vld_width got %0d exp 0", wide_cnt); else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        pif.PWM_sig = 1'b0;
        test_reset();
        test_duty80();
        test_duty00_fe();
        test_duty_ff();
        test_sig_lost();
        test_bad_period();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
